// File: rtl/char_write_arbiter_if.sv
// Terminal character-write handshake into the character buffer arbiter.
// The source drives the master side and the arbiter takes the slave side.
interface char_write_arbiter_if #(
  parameter int ROWBITS = 5
);
  logic               wrValid;
  logic               wrReady;
  logic [6:0]         wrCol;
  logic [ROWBITS-1:0] wrRow;
  logic [6:0]         wrData;

  modport master (output wrValid, wrCol, wrRow, wrData, input wrReady);
  modport slave  (input wrValid, wrCol, wrRow, wrData, output wrReady);
endinterface

// File: rtl/char_write_arbiter.sv
// Owns the character buffer RAM write port. Initialiser writes take priority over queued,
// scroll-translated terminal writes. Optional macro CHARARB_DROPCNT_EN adds a saturating dropCount output.
module char_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAXCOL     = 80,
  parameter int ROWBITS    = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 initWrEn,
  input  logic [7+ROWBITS-1:0] initAddress,
  input  logic [6:0]           initData,
  input  logic                 flushOnInit,
  char_write_arbiter_if.slave  wrIf,
  input  logic [ROWBITS-1:0]   scrollRow,
  output logic                 bufWrEn,
  output logic [7+ROWBITS-1:0] bufAddress,
  output logic [6:0]           bufData,
  output logic                 busy,
  output logic                 dropErr
`ifdef CHARARB_DROPCNT_EN
  ,
  output logic [7:0]           dropCount
`endif
);

  localparam int ADDRW  = 7 + ROWBITS;
  localparam int ENTRYW = ADDRW + 7;
  localparam int PTRW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PTRW:0]   CNT_FULL = (PTRW+1)'(FIFO_DEPTH);
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(1);
  localparam logic [PTRW:0]   CNT_ZERO = (PTRW+1)'(0);
  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
  localparam logic [6:0]      MAXCOL_C = 7'(MAXCOL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t              state_r;
  state_t              stateNext_s;

  logic [ENTRYW-1:0]   fifoMem_r [FIFO_DEPTH];
  logic [PTRW-1:0]     wrPtr_r;
  logic [PTRW-1:0]     rdPtr_r;
  logic [PTRW:0]       count_r;

  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                outOfRange_s;
  logic                store_s;
  logic                drop_s;
  logic                pop_s;
  logic                flush_s;
  logic [ROWBITS-1:0]  physRow_s;
  logic [ENTRYW-1:0]   headEntry_s;

  assign full_s       = (count_r == CNT_FULL);
  assign empty_s      = (count_r == CNT_ZERO);
  assign push_s       = wrIf.wrValid & ~full_s;
  assign outOfRange_s = (wrIf.wrCol >= MAXCOL_C);
  assign store_s      = push_s & ~outOfRange_s;
  assign drop_s       = push_s & outOfRange_s;
  // Translation happens once, at push, so later scrolling never moves queued writes.
  assign physRow_s    = wrIf.wrRow + scrollRow;
  // Only a rising init edge flushes; a continuing burst leaves the queue alone.
  assign flush_s      = initWrEn & (state_r != INIT) & flushOnInit;
  assign pop_s        = (state_r == IDLE) & ~empty_s & ~initWrEn;
  assign headEntry_s  = fifoMem_r[rdPtr_r];

  assign wrIf.wrReady = ~full_s;
  assign busy         = (state_r != IDLE) | ~empty_s;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state logic: a one-cycle guard separates an init burst from terminal drain
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (initWrEn) stateNext_s = INIT;
        else          stateNext_s = IDLE;
      end
      INIT: begin
        if (initWrEn) stateNext_s = INIT;
        else          stateNext_s = GUARD;
      end
      GUARD: begin
        if (initWrEn) stateNext_s = INIT;
        else          stateNext_s = IDLE;
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr_r <= {PTRW{1'b0}};
      rdPtr_r <= {PTRW{1'b0}};
      count_r <= CNT_ZERO;
    end else begin
      if (flush_s) begin
        // A concurrent push lands at wrPtr_r, so it becomes the sole surviving entry.
        rdPtr_r <= wrPtr_r;
        count_r <= store_s ? CNT_ONE : CNT_ZERO;
      end else begin
        if (pop_s) rdPtr_r <= rdPtr_r + PTR_ONE;
        case ({store_s, pop_s})
          2'b10:   count_r <= count_r + CNT_ONE;
          2'b01:   count_r <= count_r - CNT_ONE;
          default: count_r <= count_r;
        endcase
      end
      if (store_s) wrPtr_r <= wrPtr_r + PTR_ONE;
    end
  end

  // FIFO storage: {col, physical row, data}
  always_ff @(posedge clk) begin
    if (store_s) fifoMem_r[wrPtr_r] <= {wrIf.wrCol, physRow_s, wrIf.wrData};
  end

  // Registered RAM write port; init path wins over the FIFO path
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bufWrEn    <= 1'b0;
      bufAddress <= {ADDRW{1'b0}};
      bufData    <= 7'd0;
    end else if (initWrEn) begin
      bufWrEn    <= 1'b1;
      bufAddress <= initAddress;
      bufData    <= initData;
    end else if (pop_s) begin
      bufWrEn    <= 1'b1;
      bufAddress <= headEntry_s[ENTRYW-1:7];
      bufData    <= headEntry_s[6:0];
    end else begin
      bufWrEn    <= 1'b0;
    end
  end

`ifdef CHARARB_DROPCNT_EN
  logic [7:0] dropCount_r;

  // Saturating count of discarded out-of-range writes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dropCount_r <= 8'd0;
    end else if (drop_s && (dropCount_r != 8'hFF)) begin
      dropCount_r <= dropCount_r + 8'd1;
    end
  end

  assign dropCount = dropCount_r;
  assign dropErr   = (dropCount_r != 8'd0);
`else
  logic dropErr_r;

  // Sticky out-of-range flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dropErr_r <= 1'b0;
    end else if (drop_s) begin
      dropErr_r <= 1'b1;
    end
  end

  assign dropErr = dropErr_r;
`endif

endmodule

// File: tb/tb_char_write_arbiter.sv
// Randomised bench for char_write_arbiter against a queue-based reference model whose
// state is derived from the last two initWrEn samples.
module tb_char_write_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        initWrEn;
  logic [11:0] initAddress;
  logic [6:0]  initData;
  logic        flushOnInit;
  logic [4:0]  scrollRow;
  logic        bufWrEn;
  logic [11:0] bufAddress;
  logic [6:0]  bufData;
  logic        busy;
  logic        dropErr;
`ifdef CHARARB_DROPCNT_EN
  logic [7:0]  dropCount;
`endif

  char_write_arbiter_if wrIf ();

  char_write_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .initWrEn    (initWrEn),
    .initAddress (initAddress),
    .initData    (initData),
    .flushOnInit (flushOnInit),
    .wrIf        (wrIf),
    .scrollRow   (scrollRow),
    .bufWrEn     (bufWrEn),
    .bufAddress  (bufAddress),
    .bufData     (bufData),
    .busy        (busy),
    .dropErr     (dropErr)
`ifdef CHARARB_DROPCNT_EN
    ,
    .dropCount   (dropCount)
`endif
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;

  // reference model
  logic [18:0] mq[$];
  bit          h1, h2;
  bit          expWr;
  logic [11:0] expAddr;
  logic [6:0]  expData;
  bit          expDrop;
  int          expCnt;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    mq.delete();
    h1 = 1'b0; h2 = 1'b0;
    expWr = 1'b0; expAddr = 12'd0; expData = 7'd0;
    expDrop = 1'b0; expCnt = 0;
  endtask

  task automatic idleInputs();
    initWrEn = 1'b0; initAddress = 12'd0; initData = 7'd0; flushOnInit = 1'b0;
    wrIf.wrValid = 1'b0; wrIf.wrCol = 7'd0; wrIf.wrRow = 5'd0; wrIf.wrData = 7'd0;
  endtask

  // One clock cycle: predict from current inputs, clock, then compare.
  task automatic step(output bit acc);
    bit         idle, pop;
    logic [4:0] pr;
    idle = !h1 && !h2;
    checkEq("wrReady", wrIf.wrReady, mq.size() < 4);
    acc = wrIf.wrValid && (mq.size() < 4);
    pop = idle && (mq.size() > 0) && !initWrEn;
    if (initWrEn) begin
      expWr = 1'b1; expAddr = initAddress; expData = initData;
    end else if (pop) begin
      expWr = 1'b1; {expAddr, expData} = mq[0];
    end else begin
      expWr = 1'b0;
    end
    if (pop) void'(mq.pop_front());
    if (initWrEn && !h1 && flushOnInit) mq.delete();
    if (acc) begin
      if (wrIf.wrCol < 7'd80) begin
        pr = wrIf.wrRow + scrollRow;
        mq.push_back({wrIf.wrCol, pr, wrIf.wrData});
      end else begin
        expDrop = 1'b1;
        if (expCnt < 255) expCnt++;
      end
    end
    h2 = h1; h1 = initWrEn;
    @(posedge clk); #1;
    if (bufWrEn === 1'b1) pulses++;
    checkEq("bufWrEn", bufWrEn, expWr);
    checkEq("bufAddress", bufAddress, expAddr);
    checkEq("bufData", bufData, expData);
    checkEq("busy", busy, h1 || h2 || (mq.size() > 0));
    checkEq("dropErr", dropErr, expDrop);
`ifdef CHARARB_DROPCNT_EN
    checkEq("dropCount", dropCount, expCnt);
`endif
  endtask

  task automatic stepN(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  initial begin
    bit acc;
    bit holding;
    int initRun;
    int firstIdx;
    int found;

    resetn = 1'b0;
    idleInputs();
    scrollRow = 5'd0;
    resetModel();
    #2;
    checkEq("rstBufWrEn", bufWrEn, 1'b0);
    checkEq("rstBufAddress", bufAddress, 12'd0);
    checkEq("rstBufData", bufData, 7'd0);
    checkEq("rstWrReady", wrIf.wrReady, 1'b1);
    checkEq("rstBusy", busy, 1'b0);
    checkEq("rstDropErr", dropErr, 1'b0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // three writes at {5,2}
    for (int i = 0; i < 3; i++) begin
      wrIf.wrValid = 1'b1; wrIf.wrCol = 7'd5; wrIf.wrRow = 5'd2; wrIf.wrData = 7'(8'h41 + i);
      step(acc);
    end
    wrIf.wrValid = 1'b0;
    stepN(4);

    // scroll wrap: 3 + 30 = 33 -> row 1
    scrollRow = 5'd30;
    wrIf.wrValid = 1'b1; wrIf.wrCol = 7'd10; wrIf.wrRow = 5'd3; wrIf.wrData = 7'h5A;
    step(acc);
    wrIf.wrValid = 1'b0;
    step(acc);
    checkEq("wrapAddr", bufAddress, {7'd10, 5'd1});
    checkEq("wrapWrEn", bufWrEn, 1'b1);
    scrollRow = 5'd0;
    stepN(2);

    // fill FIFO while init holds the port
    flushOnInit = 1'b0;
    initWrEn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      initAddress = 12'($urandom); initData = 7'($urandom);
      wrIf.wrValid = 1'b1; wrIf.wrCol = 7'(i); wrIf.wrRow = 5'(i); wrIf.wrData = 7'(8'h50 + i);
      if (i == 4) checkEq("fullNotReady", wrIf.wrReady, 1'b0);
      step(acc);
    end
    wrIf.wrValid = 1'b0; initWrEn = 1'b0;
    firstIdx = 0;
    for (int i = 1; i <= 8; i++) begin
      step(acc);
      if (firstIdx == 0 && bufWrEn === 1'b1) begin
        firstIdx = i;
        checkEq("drainFirstData", bufData, 7'h50);
      end
    end
    checkEq("drainLatency", firstIdx, 3);
    stepN(2);

    // two queued entries, then 80-cycle flushing burst
    initWrEn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wrIf.wrValid = 1'b1; wrIf.wrCol = 7'd20; wrIf.wrRow = 5'(i); wrIf.wrData = 7'(8'h60 + i);
      step(acc);
    end
    wrIf.wrValid = 1'b0; initWrEn = 1'b0;
    step(acc);
    flushOnInit = 1'b1; initWrEn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      initAddress = 12'($urandom); initData = 7'($urandom);
      step(acc);
    end
    checkEq("burstPulses", pulses, 80);
    initWrEn = 1'b0; flushOnInit = 1'b0;
    pulses = 0;
    stepN(6);
    checkEq("flushedPulses", pulses, 0);

    // randomised traffic
    holding = 1'b0; initRun = 0;
    for (int c = 0; c < 600; c++) begin
      if (initRun > 0) begin
        initWrEn = 1'b1; initRun--;
      end else if ($urandom_range(0, 11) == 0) begin
        initWrEn = 1'b1; initRun = $urandom_range(0, 5);
      end else begin
        initWrEn = 1'b0;
      end
      initAddress = 12'($urandom); initData = 7'($urandom);
      flushOnInit = 1'($urandom);
      if ($urandom_range(0, 15) == 0) scrollRow = 5'($urandom);
      if (!holding) begin
        wrIf.wrValid = 1'($urandom);
        wrIf.wrCol   = 7'($urandom_range(0, 83));
        wrIf.wrRow   = 5'($urandom);
        wrIf.wrData  = 7'($urandom);
      end
      step(acc);
      holding = wrIf.wrValid && !acc;
    end
    idleInputs();
    stepN(8);

    // out-of-range push
    resetn = 1'b0; #1; resetModel(); resetn = 1'b1;
    @(posedge clk); #1;
    wrIf.wrValid = 1'b1; wrIf.wrCol = 7'd80; wrIf.wrRow = 5'd4; wrIf.wrData = 7'h33;
    step(acc);
    wrIf.wrValid = 1'b0;
    step(acc);
    checkEq("dropErrSet", dropErr, 1'b1);
    checkEq("dropNoWrite", bufWrEn, 1'b0);
`ifdef CHARARB_DROPCNT_EN
    for (int i = 0; i < 300; i++) begin
      wrIf.wrValid = 1'b1; wrIf.wrCol = 7'(80 + $urandom_range(0, 47));
      step(acc);
    end
    wrIf.wrValid = 1'b0;
    step(acc);
    checkEq("dropCountSat", dropCount, 8'd255);
`endif

    // reset mid-drain
    flushOnInit = 1'b0; initWrEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wrIf.wrValid = 1'b1; wrIf.wrCol = 7'(30 + i); wrIf.wrRow = 5'd7; wrIf.wrData = 7'(8'h70 + i);
      step(acc);
    end
    wrIf.wrValid = 1'b0; initWrEn = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step(acc);
      if (expWr && mq.size() > 0) found = 1;
    end
    checkEq("drainReached", found, 1);
    resetn = 1'b0;
    #1;
    checkEq("rstAsyncWrEn", bufWrEn, 1'b0);
    resetModel();
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    #1;
    checkEq("postRstReady", wrIf.wrReady, 1'b1);
    checkEq("postRstBusy", busy, 1'b0);
    pulses = 0;
    stepN(4);
    checkEq("postRstNoWrite", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
